// File: rtl/decl_check.sv
// decl_check: byte-serial checker for C-style declarations "type id {, id} ;".
// Optional feature macro DECL_CHECK_ARRAY_EN: accept "[digits]" suffixes after identifiers.
module decl_check #(
  parameter logic [2:0] KW_MASK    = 3'b111,
  parameter int         MAX_ID_LEN = 8,
  parameter int         MAX_VARS   = 7,
  parameter int         CNT_W      = 8,
  localparam int        VW         = $clog2(MAX_VARS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic             out,
  output logic [VW-1:0]    var_count,
  output logic [1:0]       type_id,
  output logic [CNT_W-1:0] stmt_count
);

`ifdef DECL_CHECK_ARRAY_EN
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_KW      = 4'd1,
    S_KW_WS   = 4'd2,
    S_ID      = 4'd3,
    S_ID_WS   = 4'd4,
    S_SEP     = 4'd5,
    S_ERR     = 4'd6,
    S_ARR_NUM = 4'd7,
    S_ARR_DIG = 4'd8,
    S_ARR_END = 4'd9
  } state_t;
  localparam logic [7:0] CH_LBR = 8'h5B;
  localparam logic [7:0] CH_RBR = 8'h5D;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KW    = 3'd1,
    S_KW_WS = 3'd2,
    S_ID    = 3'd3,
    S_ID_WS = 3'd4,
    S_SEP   = 3'd5,
    S_ERR   = 3'd6
  } state_t;
`endif

  localparam logic [7:0] CH_SEMI  = 8'h3B;
  localparam logic [7:0] CH_COMMA = 8'h2C;

  state_t       state_r;
  logic [1:0]   kw_r;
  logic [4:0]   len_r;
  logic [VW-1:0] vars_r;
  logic [2:0]   clash_r;
  logic [2:0]   start_mask_s;
  logic [2:0]   ext_mask_s;
  logic         clash_s;
  logic         term_s;

  function automatic logic is_ws(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h09);
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic is_id_start(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A)) || (c == 8'h5F);
  endfunction

  function automatic logic is_id_char(input logic [7:0] c);
    return is_id_start(c) || is_digit(c);
  endfunction

  // Keyword k spelled out: 0 "int", 1 "char", 2 "long".
  function automatic logic [7:0] kw_char(input logic [1:0] k, input logic [2:0] p);
    logic [7:0] c;
    case ({k, p})
      5'b00_000: c = 8'h69;
      5'b00_001: c = 8'h6E;
      5'b00_010: c = 8'h74;
      5'b01_000: c = 8'h63;
      5'b01_001: c = 8'h68;
      5'b01_010: c = 8'h61;
      5'b01_011: c = 8'h72;
      5'b10_000: c = 8'h6C;
      5'b10_001: c = 8'h6F;
      5'b10_010: c = 8'h6E;
      5'b10_011: c = 8'h67;
      default:   c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [4:0] kw_len(input logic [1:0] k);
    logic [4:0] n;
    case (k)
      2'd0:    n = 5'd3;
      2'd1:    n = 5'd4;
      2'd2:    n = 5'd4;
      default: n = 5'd0;
    endcase
    return n;
  endfunction

  // Keyword candidates for a new word, and the shadow matcher that flags identifiers equal to a keyword.
  always_comb begin
    start_mask_s = 3'b000;
    ext_mask_s   = 3'b000;
    clash_s      = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_mask_s[k] = KW_MASK[k] && (in == kw_char(2'(k), 3'd0));
      ext_mask_s[k]   = clash_r[k] && (len_r < kw_len(2'(k))) && (in == kw_char(2'(k), len_r[2:0]));
      clash_s         = clash_s || (clash_r[k] && (len_r == kw_len(2'(k))));
    end
  end

  // A ';' closes a valid statement only from a completed identifier that is not a keyword.
  always_comb begin
    term_s = 1'b0;
    if (in_valid && (in == CH_SEMI)) begin
      case (state_r)
        S_ID:      term_s = !clash_s;
        S_ID_WS:   term_s = 1'b1;
`ifdef DECL_CHECK_ARRAY_EN
        S_ARR_END: term_s = 1'b1;
`endif
        default:   term_s = 1'b0;
      endcase
    end else begin
      term_s = 1'b0;
    end
  end

  // Statement FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      kw_r       <= 2'd0;
      len_r      <= 5'd0;
      vars_r     <= VW'(1'b0);
      clash_r    <= 3'b000;
      out        <= 1'b0;
      var_count  <= VW'(1'b0);
      type_id    <= 2'd0;
      stmt_count <= CNT_W'(1'b0);
    end else begin
      out <= term_s;
      if (term_s) begin
        var_count <= vars_r;
        type_id   <= kw_r;
        if (!(&stmt_count)) begin
          stmt_count <= stmt_count + CNT_W'(1'b1);
        end else begin
          stmt_count <= stmt_count;
        end
      end
      if (in_valid) begin
        case (state_r)
          S_IDLE: begin
            if (start_mask_s[0]) begin
              state_r <= S_KW; kw_r <= 2'd0; len_r <= 5'd1;
            end else if (start_mask_s[1]) begin
              state_r <= S_KW; kw_r <= 2'd1; len_r <= 5'd1;
            end else if (start_mask_s[2]) begin
              state_r <= S_KW; kw_r <= 2'd2; len_r <= 5'd1;
            end else if (is_ws(in) || (in == CH_SEMI)) begin
              state_r <= S_IDLE;
            end else begin
              state_r <= S_ERR;
            end
          end
          S_KW: begin
            if (in == CH_SEMI) begin
              state_r <= S_IDLE;
            end else if ((len_r < kw_len(kw_r)) && (in == kw_char(kw_r, len_r[2:0]))) begin
              len_r <= len_r + 5'd1;
            end else if (is_ws(in) && (len_r == kw_len(kw_r))) begin
              state_r <= S_KW_WS;
            end else begin
              state_r <= S_ERR;
            end
          end
          S_KW_WS: begin
            if (in == CH_SEMI) begin
              state_r <= S_IDLE;
            end else if (is_ws(in)) begin
              state_r <= S_KW_WS;
            end else if (is_id_start(in)) begin
              state_r <= S_ID;
              len_r   <= 5'd1;
              vars_r  <= VW'(1'b1);
              clash_r <= start_mask_s;
            end else begin
              state_r <= S_ERR;
            end
          end
          S_ID: begin
            if (in == CH_SEMI) begin
              state_r <= S_IDLE;
            end else if (is_id_char(in)) begin
              if (len_r == 5'(MAX_ID_LEN)) begin
                state_r <= S_ERR;
              end else begin
                len_r   <= len_r + 5'd1;
                clash_r <= ext_mask_s;
              end
            end else if (is_ws(in)) begin
              state_r <= clash_s ? S_ERR : S_ID_WS;
            end else if (in == CH_COMMA) begin
              state_r <= clash_s ? S_ERR : S_SEP;
`ifdef DECL_CHECK_ARRAY_EN
            end else if (in == CH_LBR) begin
              state_r <= clash_s ? S_ERR : S_ARR_NUM;
`endif
            end else begin
              state_r <= S_ERR;
            end
          end
`ifdef DECL_CHECK_ARRAY_EN
          S_ID_WS, S_ARR_END: begin
`else
          S_ID_WS: begin
`endif
            if (in == CH_SEMI) begin
              state_r <= S_IDLE;
            end else if (is_ws(in)) begin
              state_r <= S_ID_WS;
            end else if (in == CH_COMMA) begin
              state_r <= S_SEP;
            end else begin
              state_r <= S_ERR;
            end
          end
          S_SEP: begin
            if (in == CH_SEMI) begin
              state_r <= S_IDLE;
            end else if (is_ws(in)) begin
              state_r <= S_SEP;
            end else if (is_id_start(in)) begin
              if (vars_r == VW'(MAX_VARS)) begin
                state_r <= S_ERR;
              end else begin
                state_r <= S_ID;
                len_r   <= 5'd1;
                vars_r  <= vars_r + VW'(1'b1);
                clash_r <= start_mask_s;
              end
            end else begin
              state_r <= S_ERR;
            end
          end
`ifdef DECL_CHECK_ARRAY_EN
          S_ARR_NUM: begin
            if (in == CH_SEMI) begin
              state_r <= S_IDLE;
            end else if (is_digit(in)) begin
              state_r <= S_ARR_DIG;
            end else begin
              state_r <= S_ERR;
            end
          end
          S_ARR_DIG: begin
            if (in == CH_SEMI) begin
              state_r <= S_IDLE;
            end else if (is_digit(in)) begin
              state_r <= S_ARR_DIG;
            end else if (in == CH_RBR) begin
              state_r <= S_ARR_END;
            end else begin
              state_r <= S_ERR;
            end
          end
`endif
          S_ERR: begin
            state_r <= (in == CH_SEMI) ? S_IDLE : S_ERR;
          end
          default: begin
            state_r <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decl_check.sv
// Table-driven bench for decl_check: statements streamed per character, expectations queued per ';'.
module tb_decl_check;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       dvalid;
  logic       sel;
  logic [7:0] din;
  logic       v0, v1;
  assign v0 = dvalid && !sel;
  assign v1 = dvalid && sel;

  logic       o0, o1;
  logic [2:0] vc0, vc1;
  logic [1:0] t0, t1;
  logic [7:0] c0;
  logic [1:0] c1;

  decl_check u0 (
    .clk(clk), .reset(reset), .in(din), .in_valid(v0),
    .out(o0), .var_count(vc0), .type_id(t0), .stmt_count(c0)
  );

  // "long" disabled and a 2-bit statement counter to exercise saturation.
  decl_check #(.KW_MASK(3'b011), .CNT_W(2)) u1 (
    .clk(clk), .reset(reset), .in(din), .in_valid(v1),
    .out(o1), .var_count(vc1), .type_id(t1), .stmt_count(c1)
  );

  typedef struct {
    string s;
    bit    sel;
    bit    ok;
    int    nv;
    int    ty;
    bit    gap;
  } vec_t;

  typedef struct {
    string name;
    int    dut;
    logic  o;
    int    v;
    int    t;
    int    c;
  } exp_t;

  vec_t vt[$];
  exp_t sbq[$];
  int   m_vars[2];
  int   m_type[2];
  int   m_cnt[2];
  int   m_max[2] = '{255, 3};
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input string s, input bit sl, input bit ok, input int nv, input int ty, input bit gap);
    vec_t x;
    x.s = s; x.sel = sl; x.ok = ok; x.nv = nv; x.ty = ty; x.gap = gap;
    vt.push_back(x);
  endtask

  function automatic exp_t held(input int d, input string nm);
    exp_t e;
    e.name = nm; e.dut = d; e.o = 1'b0;
    e.v = m_vars[d]; e.t = m_type[d]; e.c = m_cnt[d];
    return e;
  endfunction

  task automatic cmp(input exp_t e);
    logic ao;
    int   av, at, ac;
    if (e.dut == 0) begin
      ao = o0; av = int'(vc0); at = int'(t0); ac = int'(c0);
    end else begin
      ao = o1; av = int'(vc1); at = int'(t1); ac = int'(c1);
    end
    n_vec++;
    if ((ao !== e.o) || (av != e.v) || (at != e.t) || (ac != e.c)) begin
      n_err++;
      $display("FAIL %s (dut%0d): got out=%0b vars=%0d type=%0d cnt=%0d, expected out=%0b vars=%0d type=%0d cnt=%0d",
               e.name, e.dut, ao, av, at, ac, e.o, e.v, e.t, e.c);
    end
  endtask

  // Check the previous cycle's outputs of both instances, then drive the next character.
  task automatic step(input logic s, input logic [7:0] c, input logic v);
    exp_t e0, e1, e;
    @(negedge clk);
    e0 = held(0, "hold");
    e1 = held(1, "hold");
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.dut == 0) e0 = e;
      else e1 = e;
    end
    cmp(e0);
    cmp(e1);
    sel = s; din = c; dvalid = v;
  endtask

  task automatic run_vec(input vec_t x);
    exp_t e;
    int d;
    d = x.sel ? 1 : 0;
    for (int i = 0; i < x.s.len(); i++) begin
      step(x.sel, x.s[i], 1'b1);
      if (i == x.s.len() - 1) begin
        if (x.ok) begin
          m_vars[d] = x.nv;
          m_type[d] = x.ty;
          if (m_cnt[d] < m_max[d]) m_cnt[d]++;
        end
        e = held(d, x.s);
        e.o = x.ok;
        sbq.push_back(e);
      end
      if (x.gap) step(x.sel, 8'h3B, 1'b0);
    end
  endtask

  task automatic do_reset();
    step(sel, 8'h3B, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      m_vars[d] = 0; m_type[d] = 0; m_cnt[d] = 0;
    end
    cmp(held(0, "reset"));
    cmp(held(1, "reset"));
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; dvalid = 1'b0; sel = 1'b0; din = 8'h00;
    for (int d = 0; d < 2; d++) begin
      m_vars[d] = 0; m_type[d] = 0; m_cnt[d] = 0;
    end

    add("int a;",                   1'b0, 1'b1, 1, 0, 1'b0);
    add("char x_1 , y,z;",          1'b0, 1'b1, 3, 1, 1'b0);
    add("int int;",                 1'b0, 1'b0, 0, 0, 1'b0);
    add("long abcdefgh;",           1'b0, 1'b1, 1, 2, 1'b0);
    add("long abcdefghi;",          1'b0, 1'b0, 0, 0, 1'b0);
    add("int;",                     1'b0, 1'b0, 0, 0, 1'b0);
    add(";",                        1'b0, 1'b0, 0, 0, 1'b0);
    add("int 9a;",                  1'b0, 1'b0, 0, 0, 1'b0);
    add(" int b;",                  1'b0, 1'b1, 1, 0, 1'b0);
    add("int 9a;",                  1'b0, 1'b0, 0, 0, 1'b1);
    add(" int b;",                  1'b0, 1'b1, 1, 0, 1'b1);
    add("  int\tintx, in ;",        1'b0, 1'b1, 2, 0, 1'b0);
    add("char a,b,c,d,e,f,g;",      1'b0, 1'b1, 7, 1, 1'b0);
    add("char a,b,c,d,e,f,g,h;",    1'b0, 1'b0, 0, 0, 1'b0);
    add("Int a;",                   1'b0, 1'b0, 0, 0, 1'b0);
    add("long a,;",                 1'b0, 1'b0, 0, 0, 1'b0);
    add("lon a;",                   1'b0, 1'b0, 0, 0, 1'b0);
    add("int a b;",                 1'b0, 1'b0, 0, 0, 1'b0);
    add("char char1,_z9;",          1'b0, 1'b1, 2, 1, 1'b0);
    add("int long;",                1'b0, 1'b0, 0, 0, 1'b0);
    add("int a,char;",              1'b0, 1'b0, 0, 0, 1'b0);
    add("intx a;",                  1'b0, 1'b0, 0, 0, 1'b0);
`ifdef DECL_CHECK_ARRAY_EN
    add("int a[10],b;",             1'b0, 1'b1, 2, 0, 1'b0);
    add("int a[];",                 1'b0, 1'b0, 0, 0, 1'b0);
    add("long q[5] ;",              1'b0, 1'b1, 1, 2, 1'b0);
    add("int a[1x];",               1'b0, 1'b0, 0, 0, 1'b0);
`else
    add("int a[10];",               1'b0, 1'b0, 0, 0, 1'b0);
`endif
    add("long a;",                  1'b1, 1'b0, 0, 0, 1'b0);
    add("int long;",                1'b1, 1'b1, 1, 0, 1'b0);
    add("char a;",                  1'b1, 1'b1, 1, 1, 1'b0);
    add("int b,c;",                 1'b1, 1'b1, 2, 0, 1'b0);
    add("int d;",                   1'b1, 1'b1, 1, 0, 1'b0);
    add("int e;",                   1'b1, 1'b1, 1, 0, 1'b1);

    repeat (2) @(negedge clk);
    cmp(held(0, "reset"));
    cmp(held(1, "reset"));
    reset = 1'b0;

    foreach (vt[i]) run_vec(vt[i]);

    // Reset in the middle of a statement drops it without a pulse.
    step(1'b0, 8'h69, 1'b1);
    step(1'b0, 8'h6E, 1'b1);
    step(1'b0, 8'h74, 1'b1);
    step(1'b0, 8'h20, 1'b1);
    step(1'b0, 8'h61, 1'b1);
    do_reset();
    step(1'b0, 8'h3B, 1'b1);
    step(1'b0, 8'h3B, 1'b0);
    begin
      vec_t x;
      x.s = "int b;"; x.sel = 1'b0; x.ok = 1'b1; x.nv = 1; x.ty = 0; x.gap = 1'b0;
      run_vec(x);
    end
    step(1'b0, 8'h3B, 1'b0);
    step(1'b0, 8'h3B, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
